// File: rtl/n64_joybus_pkg.sv
// n64_joybus_pkg
//   Shared definitions for the N64 joybus transmitter:
//   - state_e   : transmitter FSM states
//   - T_*_100M  : default phase lengths in clocks at 100 MHz
//   - t_bit()   : total clocks of one encoded bit
package n64_joybus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_DATA,
        ST_TAIL,
        ST_STOP_LEAD,
        ST_STOP_TAIL
    } state_e;

    localparam int T_LEAD_100M = 100;
    localparam int T_DATA_100M = 200;
    localparam int T_TAIL_100M = 100;

    function automatic int t_bit(input int t_lead, input int t_data, input int t_tail);
        return t_lead + t_data + t_tail;
    endfunction

endpackage

// File: rtl/n64_phase_timer.sv
// n64_phase_timer
//   Loadable down-counter that times one line phase.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : start a new phase of len clocks (overrides any running phase)
//   len        : phase length in clocks, must be >= 1
//   expire     : high during the last clock of the running phase
module n64_phase_timer #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] len,
    output logic          expire
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          active_q, active_d;

    // The phase whose counter reaches zero is in its final clock.
    assign expire = active_q && (cnt_q == '0);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        cnt_d    = cnt_q;
        active_d = active_q;
        if (load) begin
            cnt_d    = len - CW'(1);
            active_d = 1'b1;
        end else if (expire) begin
            active_d = 1'b0;
        end else if (active_q) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // NOTE: flops use non-blocking assignments so all of them sample pre-edge values together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/n64_joybus_tx.sv
// n64_joybus_tx
//   Serialises a 1..MAX_BYTES frame MSB-first onto the joybus line using the
//   pulse-width code (low lead, data level, high tail per bit) and appends the
//   console stop bit.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : frame request, sampled only while idle
//   tx_len       : frame length in bytes (1..MAX_BYTES accepted)
//   tx_data      : frame bytes, byte 0 in [7:0] is sent first
//   busy         : frame in progress
//   writing_data : line ownership for the pad logic (same as busy)
//   data_out     : line level, 1 while idle
//   done         : one-cycle pulse at frame end
//   err_len      : one-cycle pulse when a start is rejected for bad length
module n64_joybus_tx
    import n64_joybus_pkg::*;
#(
    parameter  int MAX_BYTES = 4,
    parameter  int T_LEAD    = T_LEAD_100M,
    parameter  int T_DATA    = T_DATA_100M,
    parameter  int T_TAIL    = T_TAIL_100M,
    localparam int LW        = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [LW-1:0]          tx_len,
    input  logic [8*MAX_BYTES-1:0] tx_data,
    output logic                   busy,
    output logic                   writing_data,
    output logic                   data_out,
    output logic                   done,
    output logic                   err_len
);

    localparam int TMAX = (T_LEAD > T_DATA) ? ((T_LEAD > T_TAIL) ? T_LEAD : T_TAIL)
                                            : ((T_DATA > T_TAIL) ? T_DATA : T_TAIL);
    localparam int CW   = $clog2(TMAX + 1);

    state_e                 state_q, state_d;
    logic [8*MAX_BYTES-1:0] data_q, data_d;
    logic [LW-1:0]          len_q, len_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [LW-1:0]          byte_idx_q, byte_idx_d;
    logic                   busy_q, busy_d;
    logic                   data_out_q, data_out_d;
    logic                   done_q, done_d;
    logic                   err_len_q, err_len_d;

    logic                   tmr_load;
    logic [CW-1:0]          tmr_len;
    logic                   tmr_expire;

    logic [7:0]             cur_byte;
    logic                   cur_bit;
    logic                   last_bit;
    logic                   len_ok;

    n64_phase_timer #(.CW(CW)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tmr_load),
        .len    (tmr_len),
        .expire (tmr_expire)
    );

    assign len_ok = (tx_len != '0) && (tx_len <= LW'(MAX_BYTES));

    // Bit index counts 0..7 from the MSB, so bit_idx 0 selects byte[7].
    always_comb begin
        cur_byte = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (byte_idx_q == LW'(i)) cur_byte = data_q[i*8 +: 8];
        end
    end
    assign cur_bit  = cur_byte[3'd7 - bit_idx_q];
    assign last_bit = (bit_idx_q == 3'd7) && (byte_idx_q == len_q - LW'(1));

    // Outputs are computed for the state being entered, so the registered
    // line level already matches the new phase on its first clock.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        len_d      = len_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        busy_d     = busy_q;
        data_out_d = data_out_q;
        done_d     = 1'b0;
        err_len_d  = 1'b0;
        tmr_load   = 1'b0;
        tmr_len    = CW'(T_LEAD);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        data_d     = tx_data;
                        len_d      = tx_len;
                        bit_idx_d  = '0;
                        byte_idx_d = '0;
                        busy_d     = 1'b1;
                        data_out_d = 1'b0;
                        tmr_load   = 1'b1;
                        tmr_len    = CW'(T_LEAD);
                        state_d    = ST_LEAD;
                    end else begin
                        err_len_d = 1'b1;
                    end
                end
            end
            ST_LEAD: begin
                if (tmr_expire) begin
                    data_out_d = cur_bit;
                    tmr_load   = 1'b1;
                    tmr_len    = CW'(T_DATA);
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tmr_expire) begin
                    data_out_d = 1'b1;
                    tmr_load   = 1'b1;
                    tmr_len    = CW'(T_TAIL);
                    state_d    = ST_TAIL;
                end
            end
            ST_TAIL: begin
                if (tmr_expire) begin
                    data_out_d = 1'b0;
                    tmr_load   = 1'b1;
                    tmr_len    = CW'(T_LEAD);
                    if (last_bit) begin
                        state_d = ST_STOP_LEAD;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) byte_idx_d = byte_idx_q + LW'(1);
                        state_d = ST_LEAD;
                    end
                end
            end
            ST_STOP_LEAD: begin
                if (tmr_expire) begin
                    data_out_d = 1'b1;
                    tmr_load   = 1'b1;
                    tmr_len    = CW'(T_TAIL);
                    state_d    = ST_STOP_TAIL;
                end
            end
            ST_STOP_TAIL: begin
                if (tmr_expire) begin
                    busy_d     = 1'b0;
                    data_out_d = 1'b1;
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            // NOTE: the frame buffer is a plain register bank, so it takes a reset like any other flop.
            data_q     <= '0;
            len_q      <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            busy_q     <= 1'b0;
            data_out_q <= 1'b1;
            done_q     <= 1'b0;
            err_len_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            len_q      <= len_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            busy_q     <= busy_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
            err_len_q  <= err_len_d;
        end
    end

    assign busy         = busy_q;
    assign writing_data = busy_q;
    assign data_out     = data_out_q;
    assign done         = done_q;
    assign err_len      = err_len_q;

endmodule

// File: tb/tb_n64_joybus_tx.sv
// tb_n64_joybus_tx
//   Bench for n64_joybus_tx with short phases (2/4/2 clocks, 4-byte frames).
//   A per-cycle expectation queue is built from the line code itself (lead
//   low, data level, tail high per bit, then the stop bit and a done cycle)
//   and compared against the DUT on every falling edge. Directed frames add
//   hand-computed literal checks on completion edge, busy length, low-clock
//   count and the decoded byte stream.
module tb_n64_joybus_tx;
    import n64_joybus_pkg::*;

    localparam int MB     = 4;
    localparam int TL     = 2;
    localparam int TD     = 4;
    localparam int TT     = 2;
    localparam int LW     = 3;
    localparam int TB_BIT = t_bit(TL, TD, TT);

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          start   = 1'b0;
    logic [LW-1:0] tx_len  = '0;
    logic [8*MB-1:0] tx_data = '0;
    logic          busy, writing_data, data_out, done, err_len;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    n64_joybus_tx #(
        .MAX_BYTES (MB),
        .T_LEAD    (TL),
        .T_DATA    (TD),
        .T_TAIL    (TT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .tx_len       (tx_len),
        .tx_data      (tx_data),
        .busy         (busy),
        .writing_data (writing_data),
        .data_out     (data_out),
        .done         (done),
        .err_len      (err_len)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, want);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic busy;
        logic line;
        logic done;
        logic err;
    } exp_t;

    localparam exp_t IDLE_E = exp_t'(4'b0100);

    exp_t exp_q[$];
    exp_t exp_cur    = IDLE_E;
    logic model_idle = 1'b1;

    // Expected cycle-by-cycle outputs for one accepted frame.
    task automatic push_frame(input int len, input logic [31:0] data);
        logic [7:0] b;
        for (int by = 0; by < len; by++) begin
            b = data[by*8 +: 8];
            for (int i = 7; i >= 0; i--) begin
                repeat (TL) exp_q.push_back(exp_t'(4'b1000));
                repeat (TD) exp_q.push_back(exp_t'({1'b1, b[i], 2'b00}));
                repeat (TT) exp_q.push_back(exp_t'(4'b1100));
            end
        end
        repeat (TL) exp_q.push_back(exp_t'(4'b1000));
        repeat (TT) exp_q.push_back(exp_t'(4'b1100));
        exp_q.push_back(exp_t'(4'b0110));
    endtask

    always @(posedge clk or negedge rst_n) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            exp_cur    <= IDLE_E;
            model_idle <= 1'b1;
        end else begin
            if (model_idle && start) begin
                if (tx_len >= 1 && tx_len <= MB) push_frame(int'(tx_len), tx_data);
                else exp_q.push_back(exp_t'(4'b0101));
            end
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else                  e = IDLE_E;
            exp_cur    <= e;
            model_idle <= !e.busy;
        end
    end

    always @(negedge clk) begin
        check("cycle", {27'd0, busy, writing_data, data_out, done, err_len},
              {27'd0, exp_cur.busy, exp_cur.busy, exp_cur.line, exp_cur.done, exp_cur.err});
    end

    // ---------------- directed helpers ----------------
    task automatic run_frame(input int len, input logic [31:0] data, input bit mid, input bit b2b,
                             output int done_edge, output int busy_cnt, output int low_cnt,
                             output logic [31:0] decoded);
        logic line_s [1:400];
        int   idx;
        int   got;
        @(negedge clk);
        tx_len  = LW'(len);
        tx_data = data;
        start   = 1'b1;
        done_edge = 0;
        busy_cnt  = 0;
        low_cnt   = 0;
        decoded   = '0;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk); #1;
            if (n == 1) start = 1'b0;
            if (mid && n == 20) begin
                start   = 1'b1;
                tx_data = $urandom;
                tx_len  = LW'($urandom_range(1, 4));
            end
            if (mid && n == 21) start = 1'b0;
            line_s[n] = data_out;
            if (busy)      busy_cnt++;
            if (!data_out) low_cnt++;
            if (done) begin
                done_edge = n;
                break;
            end
        end
        for (int by = 0; by < len; by++) begin
            for (int i = 0; i < 8; i++) begin
                idx = 1 + (by*8 + i)*TB_BIT + TL;
                decoded[by*8 + 7 - i] = line_s[idx];
            end
        end
        if (b2b) begin
            // Start issued during the done cycle: LEAD must follow on the next edge.
            start   = 1'b1;
            tx_len  = LW'(1);
            tx_data = 32'h0000_005A;
            @(posedge clk); #1;
            start = 1'b0;
            check("b2b_lead", {30'd0, busy, data_out}, 32'b10);
            got = 0;
            for (int n = 0; n < 200; n++) begin
                @(posedge clk); #1;
                if (done) begin
                    got = 1;
                    break;
                end
            end
            check("b2b_done", got, 1);
        end
    endtask

    task automatic err_test(input int len);
        @(negedge clk);
        tx_len = LW'(len);
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("err_pulse", {27'd0, err_len, busy, writing_data, data_out, done}, 32'b10010);
        @(posedge clk); #1;
        check("err_clear", {28'd0, err_len, busy, writing_data, data_out}, 32'b0001);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          de, bc, lc, hold_done;
        logic [31:0] dec;

        repeat (3) @(posedge clk);
        #1;
        check("reset_vals", {27'd0, busy, writing_data, data_out, done, err_len}, 32'b00100);
        @(negedge clk);
        rst_n = 1'b1;

        // One zero byte: 8 x (6 low + 2 high) + stop.
        run_frame(1, 32'h0000_0000, 1'b0, 1'b0, de, bc, lc, dec);
        check("f00_done_edge", de, 69);
        check("f00_busy_cycles", bc, 68);
        check("f00_low_clocks", lc, 50);
        check("f00_decode", dec, 32'h0);

        // 0x80: only the first bit is a one (2 low + 6 high).
        run_frame(1, 32'h0000_0080, 1'b0, 1'b0, de, bc, lc, dec);
        check("f80_done_edge", de, 69);
        check("f80_low_clocks", lc, 46);
        check("f80_decode", dec, 32'h80);

        // Three bytes, byte 3 ignored, mid-frame disturbance, back-to-back follow-on.
        run_frame(3, 32'hAA03_0201, 1'b1, 1'b1, de, bc, lc, dec);
        check("f3_done_edge", de, 197);
        check("f3_busy_cycles", bc, 196);
        check("f3_low_clocks", lc, 130);
        check("f3_decode", dec, 32'h0003_0201);

        err_test(0);
        err_test(5);

        // Reset in the middle of a two-byte frame.
        @(negedge clk);
        tx_len  = LW'(2);
        tx_data = $urandom;
        start   = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            if (n == 1) start = 1'b0;
        end
        check("rst_busy_before", {31'd0, busy}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", {28'd0, busy, writing_data, data_out, done}, 32'b0010);
        hold_done = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) hold_done = 1;
        end
        check("rst_no_done", hold_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(1, 32'h0000_00A5, 1'b0, 1'b0, de, bc, lc, dec);
        check("post_rst_done_edge", de, 69);
        check("post_rst_decode", dec, 32'hA5);

        // Random traffic: random starts, lengths (including invalid) and data.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start   = ($urandom_range(0, 5) == 0);
            tx_len  = LW'($urandom_range(0, 7));
            tx_data = $urandom;
        end
        @(negedge clk);
        start = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        check("final_idle", {30'd0, busy, data_out}, 32'b01);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
